dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the far side of the pipeline's M-stage memory port.
- Takes word load/store requests (address = ALU result, store data = forwarded rt value) and holds a word-addressed RAM.
- Stores complete in zero wait states. Loads insert LATENCY wait states, driving a stall back to the hazard unit so the pipeline freezes until the load data is valid.
- Read data goes to the M/W pipeline register.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, 2..4096.
- AW, $clog2(DEPTH), word-index width; derived, not overridden.
- LATENCY, 2, load wait states; legal 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- memreq  in  1  request valid this cycle.
- memwrite  in  1  1 = store, 0 = load; qualified by memreq.
- addr  in  32  byte address; index = addr[AW+1:2]; upper bits ignored (aliasing).
- wdata  in  32  store data.
- rdata  out  32  load data, registered.
- stall  out  1  pipeline must hold F/D/E/M stages this cycle.
- err  out  1  one-cycle pulse: previous-cycle request was misaligned.

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, rdata=0, err=0, stall=0. RAM contents are NOT cleared.
- Reset mid-load: load is abandoned, stall drops immediately, no rdata update.
- Requester rule: while stall=1, memreq, memwrite, addr and wdata are held stable. The responder relies on this and does not re-latch them.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no memreq: stall=0, no state change.
- IDLE, memreq with addr[1:0]!=0 (misaligned):
  - Rejected: no write, stall=0, stays IDLE.
  - err=1 on the next cycle only; rdata unchanged.
- IDLE, aligned store (memreq=1, memwrite=1):
  - RAM[index] <= wdata at the edge; stall=0; stays IDLE.
- IDLE, aligned load (memreq=1, memwrite=0):
  - stall=1 combinationally in this cycle.
  - Latch index; cnt <= LATENCY-1.
  - Next state = DONE if LATENCY=1, else WAIT.
- WAIT: stall=1; cnt decrements each cycle. When cnt==1, rdata <= RAM[latched index] and next state = DONE.
- LATENCY=1 path: rdata <= RAM[index] is loaded at the IDLE->DONE edge.
- DONE:
  - stall=0; rdata holds the load result.
  - The still-present load request is the completing one: it is ignored, not restarted.
  - Next state = IDLE unconditionally.
- Load timing: request cycle T, stall high T..T+LATENCY-1, rdata valid and stall low at T+LATENCY.
- rdata keeps its value until the next completed load.
- Read-after-write: a store at cycle T to word k followed by a load of k at T+1 returns the new data.
- RAM: single port; read/write never overlap because stores only occur in IDLE.
- err and stall are never both 1 for the same request.
- No X on outputs after reset.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release, memreq=0 for 5 cycles -> rdata=0, stall=0, err=0 throughout.
- Store/load, LATENCY=2:
  - Store 0xDEADBEEF to addr 0x10 (stall=0 that cycle).
  - Next cycle load 0x10 -> stall=1 for exactly 2 cycles.
  - Third cycle: stall=0, rdata=0xDEADBEEF; following cycle FSM back in IDLE.
- LATENCY=1 and LATENCY=15 builds: load of a pre-stored word -> stall width exactly 1 and 15 cycles respectively; rdata correct when stall drops.
- Misaligned: store 0x12345678 to addr 0x13, then load addr 0x10 -> err=1 one cycle after the store; stall=0 on that request; load returns the old word, not 0x12345678.
- Aliasing (DEPTH=64): store 0xA5A5A5A5 to addr 0x100, then load addr 0x000 -> rdata=0xA5A5A5A5.
- Reset mid-load: assert reset during the 2nd WAIT cycle -> stall=0 immediately, rdata=0. After release, a load of the same address returns the previously stored value, showing RAM is preserved.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data memory behind the M-stage port.
// Stores finish at once; loads stall the pipe for LATENCY cycles.
module dmem_responder #(
   parameter int DEPTH   = 64,
   parameter int AW      = $clog2(DEPTH),
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memreq,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_e         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [AW-1:0]  idx_q, idx_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           err_q, err_d;
   logic [31:0]    mem_q [DEPTH];

   logic [AW-1:0]  addr_idx;
   logic [AW-1:0]  rd_idx;
   logic           aligned;
   logic           idle_req;
   logic           ld_req;
   logic           wr_en;
   logic           rd_en;
   logic           unused_addr;

   assign addr_idx    = addr[AW+1:2];
   assign aligned     = (addr[1:0] == 2'b00);
   assign idle_req    = (state_q == IDLE) && memreq;
   assign ld_req      = idle_req && aligned && !memwrite;
   assign rd_idx      = (state_q == IDLE) ? addr_idx : idx_q;
   assign unused_addr = ^addr[31:AW+2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ld_req) begin
               idx_d = addr_idx;
               cnt_d = CNT_INIT;
               if (LATENCY == 1) begin
                  state_d = DONE;
                  rd_en   = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = DONE;
               rd_en   = 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // stall drops the instant reset asserts, even with a request held
   always_comb begin
      stall   = reset && (ld_req || (state_q == WAIT));
      wr_en   = reset && idle_req && aligned && memwrite;
      err_d   = idle_req && !aligned;
      rdata_d = rd_en ? mem_q[rd_idx] : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[addr_idx] <= wdata;
      end
   end

   assign rdata = rdata_q;
   assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 2, 1 and 15.
module tb_dmem_responder;

   logic        clk;
   logic        reset;
   logic        req [3];
   logic        wr  [3];
   logic [31:0] ad  [3];
   logic [31:0] wd  [3];
   logic [31:0] rd  [3];
   logic        st  [3];
   logic        er  [3];

   int tests;
   int fails;

   dmem_responder #(.DEPTH(64), .LATENCY(2)) u_l2 (
      .clk(clk), .reset(reset), .memreq(req[0]), .memwrite(wr[0]),
      .addr(ad[0]), .wdata(wd[0]), .rdata(rd[0]), .stall(st[0]),
      .err(er[0]));

   dmem_responder #(.DEPTH(64), .LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset), .memreq(req[1]), .memwrite(wr[1]),
      .addr(ad[1]), .wdata(wd[1]), .rdata(rd[1]), .stall(st[1]),
      .err(er[1]));

   dmem_responder #(.DEPTH(64), .LATENCY(15)) u_l15 (
      .clk(clk), .reset(reset), .memreq(req[2]), .memwrite(wr[2]),
      .addr(ad[2]), .wdata(wd[2]), .rdata(rd[2]), .stall(st[2]),
      .err(er[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic q, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      req[i] = q;
      wr[i]  = w;
      ad[i]  = a;
      wd[i]  = d;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 32'h0, 32'h0);

      // reset held two cycles, then five idle cycles
      tick();
      tick();
      @(negedge clk);
      chk("rst_rdata", rd[0], 32'h0);
      chk("rst_stall", 32'(st[0]), 32'h0);
      chk("rst_err", 32'(er[0]), 32'h0);
      tick();
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("idle_rdata", rd[0], 32'h0);
         chk("idle_stall", 32'(st[0]), 32'h0);
         chk("idle_err", 32'(er[0]), 32'h0);
         tick();
      end

      // store then load, LATENCY=2
      drive(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      @(negedge clk);
      chk("st_stall", 32'(st[0]), 32'h0);
      tick();
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      chk("ld_stall_t0", 32'(st[0]), 32'h1);
      tick();
      @(negedge clk);
      chk("ld_stall_t1", 32'(st[0]), 32'h1);
      tick();
      @(negedge clk);
      chk("ld_done_stall", 32'(st[0]), 32'h0);
      chk("ld_done_rdata", rd[0], 32'hDEADBEEF);
      tick();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("ld_idle_stall", 32'(st[0]), 32'h0);
      chk("ld_idle_rdata", rd[0], 32'hDEADBEEF);
      tick();

      // misaligned store is rejected and flags err next cycle
      drive(0, 1'b1, 1'b1, 32'h13, 32'h12345678);
      @(negedge clk);
      chk("mis_stall", 32'(st[0]), 32'h0);
      chk("mis_err_now", 32'(er[0]), 32'h0);
      tick();
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      chk("mis_err_next", 32'(er[0]), 32'h1);
      chk("mis_ld_stall0", 32'(st[0]), 32'h1);
      tick();
      @(negedge clk);
      chk("mis_err_gone", 32'(er[0]), 32'h0);
      chk("mis_ld_stall1", 32'(st[0]), 32'h1);
      tick();
      @(negedge clk);
      chk("mis_ld_stall2", 32'(st[0]), 32'h0);
      chk("mis_ld_rdata", rd[0], 32'hDEADBEEF);
      tick();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);

      // aliasing: 0x100 maps onto word 0
      tick();
      drive(0, 1'b1, 1'b1, 32'h100, 32'hA5A5A5A5);
      @(negedge clk);
      chk("alias_st_stall", 32'(st[0]), 32'h0);
      tick();
      drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("alias_stall0", 32'(st[0]), 32'h1);
      tick();
      @(negedge clk);
      chk("alias_stall1", 32'(st[0]), 32'h1);
      tick();
      @(negedge clk);
      chk("alias_stall2", 32'(st[0]), 32'h0);
      chk("alias_rdata", rd[0], 32'hA5A5A5A5);
      tick();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);

      // LATENCY=1: single stall cycle
      drive(1, 1'b1, 1'b1, 32'h20, 32'h11111111);
      @(negedge clk);
      chk("l1_st_stall", 32'(st[1]), 32'h0);
      tick();
      drive(1, 1'b1, 1'b0, 32'h20, 32'h0);
      @(negedge clk);
      chk("l1_stall0", 32'(st[1]), 32'h1);
      tick();
      @(negedge clk);
      chk("l1_stall1", 32'(st[1]), 32'h0);
      chk("l1_rdata", rd[1], 32'h11111111);
      tick();
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("l1_idle_stall", 32'(st[1]), 32'h0);
      tick();

      // LATENCY=15: fifteen stall cycles
      drive(2, 1'b1, 1'b1, 32'h3C, 32'h0F0F0F0F);
      @(negedge clk);
      chk("l15_st_stall", 32'(st[2]), 32'h0);
      tick();
      drive(2, 1'b1, 1'b0, 32'h3C, 32'h0);
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         chk("l15_stall_hi", 32'(st[2]), 32'h1);
         tick();
      end
      @(negedge clk);
      chk("l15_stall_lo", 32'(st[2]), 32'h0);
      chk("l15_rdata", rd[2], 32'h0F0F0F0F);
      tick();
      drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // reset during the second WAIT cycle of a LATENCY=15 load
      drive(2, 1'b1, 1'b0, 32'h3C, 32'h0);
      @(negedge clk);
      chk("mid_stall0", 32'(st[2]), 32'h1);
      tick();
      @(negedge clk);
      chk("mid_stall1", 32'(st[2]), 32'h1);
      tick();
      @(negedge clk);
      chk("mid_stall2", 32'(st[2]), 32'h1);
      reset = 1'b0;
      #1;
      chk("mid_rst_stall", 32'(st[2]), 32'h0);
      chk("mid_rst_rdata", rd[2], 32'h0);
      chk("mid_rst_rdata0", rd[0], 32'h0);
      tick();
      drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rel_stall", 32'(st[2]), 32'h0);
      chk("mid_rel_rdata", rd[2], 32'h0);
      tick();
      drive(2, 1'b1, 1'b0, 32'h3C, 32'h0);
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         chk("mid_re_stall", 32'(st[2]), 32'h1);
         tick();
      end
      @(negedge clk);
      chk("mid_re_done", 32'(st[2]), 32'h0);
      chk("mid_re_rdata", rd[2], 32'h0F0F0F0F);
      tick();
      drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
